pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage F/D/X/M/W pipeline. It watches the register usage in D, the load in X, the branch resolution in M and the data-memory handshake in M. It drives per-stage enable, flush and bubble controls into FetchStage and the FD/DX/XM/MW pipeline registers. It replaces the shared ready_i tie-off and the branchTaken-as-flush wiring with one sequenced source of control. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
FLUSH_CYCLES, 1, cycles fd_flush_o stays asserted after a taken branch; range 1..7. Covers instruction-memory latency.
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_err_o is set; 0 disables the timeout.
CNT_W, 16, width of each performance counter.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
d_rs1_i  in  5  rs1 index of the instruction in D
d_rs2_i  in  5  rs2 index of the instruction in D
d_use_rs1_i  in  1  D instruction reads rs1
d_use_rs2_i  in  1  D instruction reads rs2
x_rd_i  in  5  rd of the instruction in X (DX output)
x_memread_i  in  1  X instruction is a load
branch_taken_i  in  1  branch resolved taken in M (one-cycle pulse)
mem_req_i  in  1  M instruction accesses data memory (MemRead or MemWrite)
mem_ack_i  in  1  data memory completes the access this cycle
pc_en_o  out  1  PC update enable
fd_en_o  out  1  FD register load enable
dx_en_o  out  1  DX register load enable
xm_en_o  out  1  XM register load enable
mw_en_o  out  1  MW register load enable
fd_flush_o  out  1  clear FD to NOP
dx_flush_o  out  1  clear DX to NOP (all control bits 0)
xm_flush_o  out  1  clear XM to NOP
mw_bubble_o  out  1  load NOP into MW (RegWrite=0)
state_o  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 FLUSH, 3 MEM_WAIT
mem_err_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  load-use plus memory-wait stall cycles, saturating
flush_cnt_o  out  CNT_W  taken branches, saturating

Behaviour:
- Reset (clk_i edge with reset_i=1):
  - state=RUN, counters=0, mem_err_o=0, flush down-counter=0, timeout counter=0.
  - While reset is asserted, all enables=1, all flush/bubble=0. Reset mid-operation aborts any state with no residual stall.
- Load-use hazard: lu = x_memread_i & (x_rd_i!=0) & ((d_use_rs1_i & x_rd_i==d_rs1_i) | (d_use_rs2_i & x_rd_i==d_rs2_i)).
- Priority each cycle: branch_taken_i > memory wait > load-use.
- RUN:
  - branch_taken_i=1: fd_flush_o=dx_flush_o=xm_flush_o=1 the same cycle; pc_en_o=1 so the redirect loads. flush_cnt++.
    - FLUSH_CYCLES>1: go to FLUSH with down-counter=FLUSH_CYCLES-1.
    - FLUSH_CYCLES=1: stay in RUN.
  - else mem_req_i & !mem_ack_i: pc/fd/dx/xm_en_o=0, mw_en_o=1, mw_bubble_o=1. Go to MEM_WAIT; timeout counter=1; stall_cnt++.
  - else lu: pc_en_o=fd_en_o=0, dx_flush_o=1 (bubble into X), xm/mw enabled. Go to LU_STALL; stall_cnt++.
  - else: all enables=1, no flush.
- LU_STALL: exactly one cycle; outputs as in RUN with no hazard (lu cannot recur because the load has moved to M). A branch_taken_i here is handled as in RUN. Next state RUN (or FLUSH per the branch rule).
- FLUSH: fd_flush_o=1, pc_en_o=1, other stages run. Down-counter decrements each cycle; exit to RUN when it reaches 1. A new branch_taken_i reloads the counter and increments flush_cnt.
- MEM_WAIT:
  - Outputs held as on entry; stall_cnt++ each cycle.
  - mem_ack_i=1: release the same cycle (all enables=1, no bubble) and go to RUN.
  - Timeout counter increments each cycle. At count==MEM_TIMEOUT (when nonzero): set mem_err_o, force-release to RUN.
  - branch_taken_i is ignored in MEM_WAIT; the M instruction is frozen, so no pulse is legal.
- Counters saturate at all-ones and never wrap. mem_err_o clears only on reset.
- All outputs other than the counters, state_o and mem_err_o are combinational from the state and inputs. Input-to-enable latency is 0 cycles.

Test Plan:
- Load-use: ld x5 in X (x_memread_i=1, x_rd_i=5), D reads rs1=5 with d_use_rs1_i=1.
  -> pc_en_o=fd_en_o=0, dx_flush_o=1 for 1 cycle; state_o 0->1->0; stall_cnt_o=1.
- x0 load: same as above but x_rd_i=0 -> no stall; stall_cnt_o stays 0.
- Branch vs load-use: branch_taken_i=1 in the same cycle as lu.
  -> fd/dx/xm flush=1, pc_en_o=1, no stall; flush_cnt_o=1.
  -> With FLUSH_CYCLES=3: fd_flush_o high for 3 cycles total.
- Memory wait: mem_req_i=1, mem_ack_i low for 4 cycles then high.
  -> enables pc..xm=0 and mw_bubble_o=1 for 4 cycles, release on the ack cycle; stall_cnt_o=4.
- Timeout: MEM_TIMEOUT=8, mem_ack_i never asserts.
  -> mem_err_o=1 after 8 cycles, state_o=RUN.
  -> Then assert reset_i mid-LU_STALL -> state_o=0, all enables 1, counters 0, mem_err_o 0.
- Saturation: CNT_W=4, 20 taken branches -> flush_cnt_o=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// The master side is the controller; the slave side is the datapath/testbench.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       d_rs1_i;
    logic [4:0]       d_rs2_i;
    logic             d_use_rs1_i;
    logic             d_use_rs2_i;
    logic [4:0]       x_rd_i;
    logic             x_memread_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;

    logic             pc_en_o;
    logic             fd_en_o;
    logic             dx_en_o;
    logic             xm_en_o;
    logic             mw_en_o;
    logic             fd_flush_o;
    logic             dx_flush_o;
    logic             xm_flush_o;
    logic             mw_bubble_o;
    logic [1:0]       state_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        input  d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i, x_rd_i, x_memread_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o,
               fd_flush_o, dx_flush_o, xm_flush_o, mw_bubble_o,
               state_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        output d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i, x_rd_i, x_memread_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o,
               fd_flush_o, dx_flush_o, xm_flush_o, mw_bubble_o,
               state_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D/X/M/W pipeline with saturating
// stall/flush event counters and a sticky data-memory timeout flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    pipeline_hazard_ctrl_if.master hz
);
    localparam int unsigned FC_W = 3;
    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEM   = 2'd3
    } state_t;

    state_t           state;
    logic [FC_W-1:0]  flush_left;
    logic [TO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_err;

    logic lu_c;
    logic mem_pend_c;
    logic to_hit_c;
    logic run_like_c;
    logic br_c;
    logic mem_enter_c;
    logic lu_enter_c;
    logic mem_hold_c;
    logic stall_inc_c;

    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_flush;
    logic dx_flush;
    logic xm_flush;
    logic mw_bubble;

    // Hazard decode shared by the output and sequencing logic.
    always_comb begin
        lu_c        = hz.x_memread_i && (hz.x_rd_i != 5'd0) &&
                      ((hz.d_use_rs1_i && (hz.x_rd_i == hz.d_rs1_i)) ||
                       (hz.d_use_rs2_i && (hz.x_rd_i == hz.d_rs2_i)));
        mem_pend_c  = hz.mem_req_i && !hz.mem_ack_i;
        to_hit_c    = (MEM_TIMEOUT != 0) && (wait_cnt == TO_W'(MEM_TIMEOUT));
        run_like_c  = (state == ST_RUN) || (state == ST_LU);
        // A frozen M stage cannot resolve a branch, so MEM_WAIT ignores the pulse.
        br_c        = hz.branch_taken_i && (state != ST_MEM);
        mem_enter_c = run_like_c && !hz.branch_taken_i && mem_pend_c;
        lu_enter_c  = (state == ST_RUN) && !hz.branch_taken_i && !mem_pend_c && lu_c;
        mem_hold_c  = (state == ST_MEM) && !hz.mem_ack_i && !to_hit_c;
        stall_inc_c = mem_enter_c || lu_enter_c || mem_hold_c;
    end

    // Zero-latency stage controls; reset forces a free-running pipeline.
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        xm_en     = 1'b1;
        mw_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        mw_bubble = 1'b0;
        if (!reset_i) begin
            if (br_c) begin
                fd_flush = 1'b1;
                dx_flush = 1'b1;
                xm_flush = 1'b1;
            end else if (mem_enter_c || mem_hold_c) begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_en     = 1'b0;
                mw_bubble = 1'b1;
            end else if (lu_enter_c) begin
                pc_en    = 1'b0;
                fd_en    = 1'b0;
                dx_flush = 1'b1;
            end else if (state == ST_FLUSH) begin
                fd_flush = 1'b1;
            end
        end
    end

    // Sequencer, timeout tracking and saturating event counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_RUN;
            flush_left <= '0;
            wait_cnt   <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (br_c) begin
                flush_left <= FC_W'(FLUSH_CYCLES - 1);
                state      <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            end else if (mem_enter_c) begin
                state    <= ST_MEM;
                wait_cnt <= TO_W'(1);
            end else if (lu_enter_c) begin
                state <= ST_LU;
            end else begin
                case (state)
                    ST_LU: state <= ST_RUN;
                    ST_FLUSH: begin
                        if (flush_left <= FC_W'(1)) begin
                            state      <= ST_RUN;
                            flush_left <= '0;
                        end else begin
                            flush_left <= flush_left - FC_W'(1);
                        end
                    end
                    ST_MEM: begin
                        if (hz.mem_ack_i) begin
                            state <= ST_RUN;
                        end else if (to_hit_c) begin
                            state   <= ST_RUN;
                            mem_err <= 1'b1;
                        end else if (MEM_TIMEOUT != 0) begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end

            if (stall_inc_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_c && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en_o     = pc_en;
    assign hz.fd_en_o     = fd_en;
    assign hz.dx_en_o     = dx_en;
    assign hz.xm_en_o     = xm_en;
    assign hz.mw_en_o     = mw_en;
    assign hz.fd_flush_o  = fd_flush;
    assign hz.dx_flush_o  = dx_flush;
    assign hz.xm_flush_o  = xm_flush;
    assign hz.mw_bubble_o = mw_bubble;
    assign hz.state_o     = 2'(state);
    assign hz.mem_err_o   = mem_err;
    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle comparison against a
// behavioural model plus hand-computed checkpoints.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned FC   = 3;
    localparam int unsigned TO   = 8;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .hz     (hz)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: remaining extra flush cycles, cycles spent waiting on memory,
    // whether last cycle started a load-use bubble, plus event tallies.
    int m_flush_left = 0;
    int m_wait       = 0;
    int m_lu_last    = 0;
    int m_err        = 0;
    int m_stall      = 0;
    int m_flush      = 0;

    int e_pc, e_fd, e_dx, e_xm, e_mw, e_ff, e_df, e_xf, e_bub, e_state;
    bit br_m, lu_m, stall_now, lu_now;
    int nxt_lu;

    always @(negedge clk) begin
        lu_m = hz.x_memread_i && (hz.x_rd_i != 5'd0) &&
               ((hz.d_use_rs1_i && hz.x_rd_i == hz.d_rs1_i) ||
                (hz.d_use_rs2_i && hz.x_rd_i == hz.d_rs2_i));
        br_m = hz.branch_taken_i && (m_wait == 0);
        e_pc = 1; e_fd = 1; e_dx = 1; e_xm = 1; e_mw = 1;
        e_ff = 0; e_df = 0; e_xf = 0; e_bub = 0;
        stall_now = 1'b0;
        lu_now    = 1'b0;
        if (!rst) begin
            if (br_m) begin
                e_ff = 1; e_df = 1; e_xf = 1;
            end else if (m_wait > 0) begin
                stall_now = !hz.mem_ack_i && (m_wait != TO);
            end else if (m_flush_left > 0) begin
                e_ff = 1;
            end else if (hz.mem_req_i && !hz.mem_ack_i) begin
                stall_now = 1'b1;
            end else if (lu_m && m_lu_last == 0) begin
                lu_now = 1'b1;
                e_pc = 0; e_fd = 0; e_df = 1;
            end
            if (stall_now) begin
                e_pc = 0; e_fd = 0; e_dx = 0; e_xm = 0; e_bub = 1;
            end
        end
        e_state = (m_wait > 0) ? 3 : (m_flush_left > 0) ? 2 : (m_lu_last != 0) ? 1 : 0;

        if (armed) begin
            check("cyc_pc_en",     hz.pc_en_o,     e_pc);
            check("cyc_fd_en",     hz.fd_en_o,     e_fd);
            check("cyc_dx_en",     hz.dx_en_o,     e_dx);
            check("cyc_xm_en",     hz.xm_en_o,     e_xm);
            check("cyc_mw_en",     hz.mw_en_o,     e_mw);
            check("cyc_fd_flush",  hz.fd_flush_o,  e_ff);
            check("cyc_dx_flush",  hz.dx_flush_o,  e_df);
            check("cyc_xm_flush",  hz.xm_flush_o,  e_xf);
            check("cyc_mw_bubble", hz.mw_bubble_o, e_bub);
            check("cyc_state",     hz.state_o,     e_state);
            check("cyc_mem_err",   hz.mem_err_o,   m_err);
            check("cyc_stall_cnt", hz.stall_cnt_o, m_stall);
            check("cyc_flush_cnt", hz.flush_cnt_o, m_flush);
        end

        // Advance the model to what the next clock edge produces.
        if (rst) begin
            m_flush_left = 0; m_wait = 0; m_lu_last = 0;
            m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            nxt_lu = 0;
            if (br_m) begin
                if (m_flush < MAXC) m_flush++;
                m_flush_left = FC - 1;
            end else if (m_wait > 0) begin
                if (hz.mem_ack_i) m_wait = 0;
                else if (m_wait == TO) begin m_err = 1; m_wait = 0; end
                else m_wait++;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (hz.mem_req_i && !hz.mem_ack_i) begin
                m_wait = 1;
            end else if (lu_now) begin
                nxt_lu = 1;
            end
            m_lu_last = nxt_lu;
            if ((stall_now || lu_now) && m_stall < MAXC) m_stall++;
        end
    end

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] xrd, input logic xmr,
                         input logic br, input logic req, input logic ack);
        hz.d_rs1_i = rs1; hz.d_rs2_i = rs2; hz.d_use_rs1_i = u1; hz.d_use_rs2_i = u2;
        hz.x_rd_i = xrd; hz.x_memread_i = xmr; hz.branch_taken_i = br;
        hz.mem_req_i = req; hz.mem_ack_i = ack;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        check("rst_pc_en_comb", hz.pc_en_o, 1);
        tick(); tick();
        check("rst_state", hz.state_o, 0);
        check("rst_stall_cnt", hz.stall_cnt_o, 0);
        check("rst_flush_cnt", hz.flush_cnt_o, 0);
        armed = 1'b1;
        rst = 1'b0;

        // load-use on rs1 = x5
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("lu_pc_en", hz.pc_en_o, 0);
        check("lu_fd_en", hz.fd_en_o, 0);
        check("lu_dx_flush", hz.dx_flush_o, 1);
        tick(); idle(); #1;
        check("lu_state_stall", hz.state_o, 1);
        check("lu_pc_en_after", hz.pc_en_o, 1);
        tick();
        check("lu_state_back", hz.state_o, 0);
        check("lu_stall_cnt", hz.stall_cnt_o, 1);

        // load to x0 never stalls
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("x0_pc_en", hz.pc_en_o, 1);
        tick(); idle(); #1;
        check("x0_stall_cnt", hz.stall_cnt_o, 1);

        // rs2 load-use also detected
        drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("lu2_fd_en", hz.fd_en_o, 0);
        tick(); idle(); tick();
        check("lu2_stall_cnt", hz.stall_cnt_o, 2);

        // branch beats load-use; fd_flush spans FLUSH_CYCLES cycles
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        check("bl_fd_flush", hz.fd_flush_o, 1);
        check("bl_dx_flush", hz.dx_flush_o, 1);
        check("bl_xm_flush", hz.xm_flush_o, 1);
        check("bl_pc_en", hz.pc_en_o, 1);
        check("bl_fd_en", hz.fd_en_o, 1);
        tick(); idle(); #1;
        check("bl_flush_cnt", hz.flush_cnt_o, 1);
        check("bl_state", hz.state_o, 2);
        check("bl_fd_flush_2", hz.fd_flush_o, 1);
        tick();
        check("bl_fd_flush_3", hz.fd_flush_o, 1);
        tick();
        check("bl_fd_flush_end", hz.fd_flush_o, 0);
        check("bl_state_end", hz.state_o, 0);
        check("bl_stall_cnt", hz.stall_cnt_o, 2);

        // memory wait: 4 stalled cycles then ack
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        check("mw_pc_en", hz.pc_en_o, 0);
        check("mw_xm_en", hz.xm_en_o, 0);
        check("mw_mw_en", hz.mw_en_o, 1);
        check("mw_bubble", hz.mw_bubble_o, 1);
        repeat (4) tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        check("mw_ack_state", hz.state_o, 3);
        check("mw_ack_pc_en", hz.pc_en_o, 1);
        check("mw_ack_bubble", hz.mw_bubble_o, 0);
        tick(); idle(); #1;
        check("mw_stall_cnt", hz.stall_cnt_o, 6);
        check("mw_state", hz.state_o, 0);

        // timeout: ack never comes, forced release after MEM_TIMEOUT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) tick();
        check("to_release_pc_en", hz.pc_en_o, 1);
        check("to_err_before", hz.mem_err_o, 0);
        tick(); idle(); #1;
        check("to_mem_err", hz.mem_err_o, 1);
        check("to_state", hz.state_o, 0);
        check("to_stall_cnt", hz.stall_cnt_o, 14);

        // reset while in LU_STALL
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; #1;
        check("rs_state_lu", hz.state_o, 1);
        check("rs_pc_en", hz.pc_en_o, 1);
        check("rs_bubble", hz.mw_bubble_o, 0);
        tick(); idle(); rst = 1'b0; #1;
        check("rs_state", hz.state_o, 0);
        check("rs_stall_cnt", hz.stall_cnt_o, 0);
        check("rs_flush_cnt", hz.flush_cnt_o, 0);
        check("rs_mem_err", hz.mem_err_o, 0);

        // 20 taken branches saturate a 4-bit counter
        repeat (20) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick(); idle(); tick();
        end
        check("sat_flush_cnt", hz.flush_cnt_o, 15);
        repeat (3) tick();

        // three timeouts (24 stall cycles) saturate stall_cnt
        repeat (3) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            repeat (9) tick();
            idle(); tick();
        end
        check("sat_stall_cnt", hz.stall_cnt_o, 15);
        check("sat_flush_hold", hz.flush_cnt_o, 15);
        check("sat_mem_err", hz.mem_err_o, 1);

        idle();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
